cm138_rr_sel_ctrl: RTL

- Round-robin arbiter and sequencer for the 3-to-8 active-low select decoder.
- Eight requesters share one decoded select bus; the block picks one requester and drives the 3-bit index plus the decoder-style enable.
- It also produces the registered active-low one-hot select (gnt_n), with break-before-make between owners.
- Sits between requesting agents and the shared resource selected by the decoder.

---
 rtl/cm138_rr_sel_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cm138_rr_sel_ctrl.sv
// Round-robin arbiter/sequencer driving a 3-to-8 active-low select decoder.
// Optional hold timeout is compiled in when CM138_HOLD_TIMEOUT_EN is defined.
module cm138_rr_sel_ctrl #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt_n,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       sel_en_n,
    output logic       timeout
);

    // Handshake: req[i] is a level; agent i owns the resource while gnt_valid=1
    // and gnt_idx=i, and releases it by dropping req[i]. No other ready signal.

    if (HOLD_MAX < 1 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_bad_param
        $error("cm138_rr_sel_ctrl: HOLD_MAX/CNT_W out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] ptr;
    logic [2:0] ptr_nxt;
    logic [2:0] winner;
    logic [2:0] cand;
    logic       found;
    logic       rel_normal;
    logic       force_rel;

    logic [7:0] gnt_n_nxt;
    logic [2:0] gnt_idx_nxt;
    logic       gnt_valid_nxt;
    logic       timeout_nxt;

    // Rotating priority search: first requester at or after ptr, wrapping 7->0.
    always_comb begin
        winner = ptr;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign rel_normal = !req[gnt_idx] || !en;

`ifdef CM138_HOLD_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;

    // Counts completed GRANT cycles; the HOLD_MAX-th cycle is the last one.
    assign force_rel = (state == GRANT) && (hold_cnt == CNT_W'(HOLD_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (state != GRANT) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (en && found) state_nxt = GRANT;
            end
            GRANT: begin
                if (rel_normal || force_rel) begin
                    state_nxt = GAP;
                    ptr_nxt   = gnt_idx + 3'd1;
                end
            end
            GAP: begin
                state_nxt = (en && found) ? GRANT : IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output logic: computed from the next state so every output is a flop.
    always_comb begin
        gnt_n_nxt     = 8'hFF;
        gnt_idx_nxt   = 3'd0;
        gnt_valid_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        if (state_nxt == GRANT) begin
            gnt_valid_nxt = 1'b1;
            if (state == GRANT) begin
                gnt_n_nxt   = gnt_n;
                gnt_idx_nxt = gnt_idx;
            end else begin
                gnt_n_nxt   = ~(8'b1 << winner);
                gnt_idx_nxt = winner;
            end
        end
        if (state == GRANT && state_nxt == GAP && !rel_normal) begin
            timeout_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_n     <= 8'hFF;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            sel_en_n  <= 1'b1;
            timeout   <= 1'b0;
        end else begin
            gnt_n     <= gnt_n_nxt;
            gnt_idx   <= gnt_idx_nxt;
            gnt_valid <= gnt_valid_nxt;
            sel_en_n  <= ~gnt_valid_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule
